// File: rtl/pe_sched_pkg.sv
// Shared definitions for the Wishbone request scheduler: register offsets, CTRL bits, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pe_sched_pkg;

   // Register offsets within the 256-byte window (adr[7:0]).
   localparam logic [7:0] CTRL_OFF = 8'h00;
   localparam logic [7:0] MASK_OFF = 8'h04;
   localparam logic [7:0] PEND_OFF = 8'h08;
   localparam logic [7:0] GNT_OFF  = 8'h0C;
   localparam logic [7:0] ACK_OFF  = 8'h10;

   // CTRL bit positions.
   localparam int CTRL_EN     = 0;
   localparam int CTRL_MODE   = 1;
   localparam int CTRL_IRQ_EN = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      RETIRE = 2'd2
   } sched_state_t;

endpackage

// File: rtl/pe_rr_encoder.sv
// Priority encoder with a start pointer: highest set bit (fixed) or first set bit at/after start (round-robin).
// Latency: purely combinational.
// Backpressure: none.
// Ports: cand (candidate vector), start (round-robin start index), rr_mode (1 = round-robin),
//        idx (winner index), onehot (winner one-hot), any (at least one candidate).
module pe_rr_encoder #(
   parameter int NREQ = 8,
   parameter int IDXW = 3
) (
   input  logic [NREQ-1:0] cand,
   input  logic [IDXW-1:0] start,
   input  logic            rr_mode,
   output logic [IDXW-1:0] idx,
   output logic [NREQ-1:0] onehot,
   output logic            any
);

   int j;

   always_comb begin
      idx    = '0;
      any    = 1'b0;
      onehot = '0;
      j      = 0;
      if (rr_mode) begin
         // Scan NREQ positions starting at 'start', wrapping; first hit wins.
         for (int i = 0; i < NREQ; i++) begin
            j = int'(start) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!any && cand[j]) begin
               idx = IDXW'(j);
               any = 1'b1;
            end
         end
      end else begin
         // Ascending scan, last hit wins, so the highest index is selected.
         for (int i = 0; i < NREQ; i++) begin
            if (cand[i]) begin
               idx = IDXW'(i);
               any = 1'b1;
            end
         end
      end
      if (any) onehot[idx] = 1'b1;
   end

endmodule

// File: rtl/pe_req_scheduler.sv
// Wishbone-controlled request scheduler: sticky pending bits, fixed/round-robin winner, grant held until firmware ACK.
// Latency: req_i -> pending +1 cycle -> grant +2 cycles; Wishbone ack one cycle after selection, read data alongside.
// Backpressure: grant held until ACK write (or EN cleared); ack never asserted in two consecutive cycles.
// Ports: wb_clk_i/wb_rst_i clock and sync reset; wbs_* Wishbone slave; req_i level requests;
//        gnt_o/gnt_idx_o/gnt_valid_o latched grant; irq_o registered grant interrupt.
module pe_req_scheduler
   import pe_sched_pkg::*;
#(
   parameter int          NREQ      = 8,
   parameter int          IDXW      = $clog2(NREQ),
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic            wbs_stb_i,
   input  logic            wbs_cyc_i,
   input  logic            wbs_we_i,
   input  logic [3:0]      wbs_sel_i,
   input  logic [31:0]     wbs_dat_i,
   input  logic [31:0]     wbs_adr_i,
   output logic            wbs_ack_o,
   output logic [31:0]     wbs_dat_o,
   input  logic [NREQ-1:0] req_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IDXW-1:0] gnt_idx_o,
   output logic            gnt_valid_o,
   output logic            irq_o
);

   logic [2:0]      ctrl;
   logic [NREQ-1:0] mask;
   logic [NREQ-1:0] mask_nxt;
   logic [NREQ-1:0] pending;
   logic [NREQ-1:0] w1c_clr;
   logic [NREQ-1:0] ret_clr;
   logic [NREQ-1:0] cand;
   logic [NREQ-1:0] enc_onehot;
   logic [IDXW-1:0] enc_idx;
   logic [IDXW-1:0] rr_ptr;
   logic            enc_any;
   logic [7:0]      off;
   logic            wb_sel;
   logic            wb_wr;
   logic            ack_req;
   logic [31:0]     rdata;
   logic            latch_gnt;
   logic            drop_gnt;
   logic            retire;
   sched_state_t    state;
   sched_state_t    state_nxt;

   // Data/select bits beyond NREQ and byte lanes without a register bit are intentionally ignored.
   logic unused_ok;
   assign unused_ok = &{1'b0, wbs_dat_i, wbs_sel_i};

   assign off    = wbs_adr_i[7:0];
   assign wb_sel = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   // Writes commit on the edge that closes the ack cycle, while the master still holds the cycle.
   assign wb_wr  = wb_sel & wbs_we_i & wbs_ack_o;
   assign ack_req = wb_wr & (off == ACK_OFF) & wbs_sel_i[0] & wbs_dat_i[0];

   assign cand    = pending & mask;
   assign ret_clr = retire ? gnt_o : '0;

   pe_rr_encoder #(
      .NREQ (NREQ),
      .IDXW (IDXW)
   ) u_enc (
      .cand    (cand),
      .start   (rr_ptr),
      .rr_mode (ctrl[CTRL_MODE]),
      .idx     (enc_idx),
      .onehot  (enc_onehot),
      .any     (enc_any)
   );

   // Byte-lane merge for MASK and byte-lane W1C for PENDING.
   always_comb begin
      mask_nxt = mask;
      w1c_clr  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (wb_wr && off == MASK_OFF && wbs_sel_i[i/8]) mask_nxt[i] = wbs_dat_i[i];
         if (wb_wr && off == PEND_OFF && wbs_sel_i[i/8]) w1c_clr[i] = wbs_dat_i[i];
      end
   end

   always_comb begin
      rdata = '0;
      case (off)
         CTRL_OFF: rdata = {29'b0, ctrl};
         MASK_OFF: rdata = 32'(mask);
         PEND_OFF: rdata = 32'(pending);
         GNT_OFF:  rdata = {gnt_valid_o, {(31-IDXW){1'b0}}, gnt_idx_o};
         default:  rdata = '0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      latch_gnt = 1'b0;
      drop_gnt  = 1'b0;
      retire    = 1'b0;
      case (state)
         IDLE: begin
            if (ctrl[CTRL_EN] && enc_any) begin
               state_nxt = GRANT;
               latch_gnt = 1'b1;
            end
         end
         GRANT: begin
            // Disabling abandons the grant without retiring it; the pending bit survives.
            if (!ctrl[CTRL_EN]) begin
               state_nxt = IDLE;
               drop_gnt  = 1'b1;
            end else if (ack_req) begin
               state_nxt = RETIRE;
            end
         end
         RETIRE: begin
            state_nxt = IDLE;
            drop_gnt  = 1'b1;
            retire    = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state <= IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wbs_ack_o   <= 1'b0;
         wbs_dat_o   <= '0;
         ctrl        <= '0;
         mask        <= '1;
         pending     <= '0;
         rr_ptr      <= '0;
         gnt_o       <= '0;
         gnt_idx_o   <= '0;
         gnt_valid_o <= 1'b0;
         irq_o       <= 1'b0;
      end else begin
         // Gating with the current ack splits a held strobe into separate accesses.
         wbs_ack_o <= wb_sel & ~wbs_ack_o;
         wbs_dat_o <= (wb_sel & ~wbs_ack_o & ~wbs_we_i) ? rdata : '0;

         if (wb_wr && off == CTRL_OFF && wbs_sel_i[0]) ctrl <= wbs_dat_i[2:0];
         mask <= mask_nxt;

         // Clear wins in the same cycle; a held request re-pends one cycle later.
         pending <= (pending | req_i) & ~(w1c_clr | ret_clr);

         if (latch_gnt) begin
            gnt_o       <= enc_onehot;
            gnt_idx_o   <= enc_idx;
            gnt_valid_o <= 1'b1;
         end else if (drop_gnt) begin
            gnt_o       <= '0;
            gnt_idx_o   <= '0;
            gnt_valid_o <= 1'b0;
         end

         if (retire) begin
            rr_ptr <= (gnt_idx_o == IDXW'(NREQ-1)) ? '0 : gnt_idx_o + IDXW'(1);
         end

         irq_o <= gnt_valid_o & ctrl[CTRL_IRQ_EN];
      end
   end

endmodule

// File: tb/tb_pe_req_scheduler.sv
// Directed bench for pe_req_scheduler: register access, fixed and round-robin grants, masking, EN drop, Wishbone timing.
// Latency: n/a.
// Backpressure: n/a.
module tb_pe_req_scheduler;

   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stb = 1'b0;
   logic        cyc = 1'b0;
   logic        we  = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] dat_w = '0;
   logic [31:0] adr = '0;
   logic        ack;
   logic [31:0] dat_r;
   logic [7:0]  req = '0;
   logic [7:0]  gnt;
   logic [2:0]  gnt_idx;
   logic        gnt_valid;
   logic        irq;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pe_req_scheduler #(
      .NREQ      (8),
      .IDXW      (3),
      .BASE_ADDR (BASE)
   ) dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst),
      .wbs_stb_i   (stb),
      .wbs_cyc_i   (cyc),
      .wbs_we_i    (we),
      .wbs_sel_i   (sel),
      .wbs_dat_i   (dat_w),
      .wbs_adr_i   (adr),
      .wbs_ack_o   (ack),
      .wbs_dat_o   (dat_r),
      .req_i       (req),
      .gnt_o       (gnt),
      .gnt_idx_o   (gnt_idx),
      .gnt_valid_o (gnt_valid),
      .irq_o       (irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // All tasks start and end 1 time unit after a rising edge.
   task automatic wb_write(input logic [7:0] o, input logic [31:0] d, input logic [3:0] s);
      logic got;
      got = 1'b0;
      stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE | 32'(o); dat_w = d; sel = s;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge clk); #1;
         if (ack) got = 1'b1;
      end
      check("wr_ack_seen", 32'(got), 1);
      @(posedge clk); #1;
      stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; dat_w = '0;
   endtask

   task automatic wb_read(input logic [7:0] o, output logic [31:0] d);
      logic got;
      got = 1'b0;
      d = 'x;
      stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE | 32'(o); sel = 4'hF;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge clk); #1;
         if (ack) begin
            got = 1'b1;
            d = dat_r;
         end
      end
      check("rd_ack_seen", 32'(got), 1);
      @(posedge clk); #1;
      stb = 1'b0; cyc = 1'b0; sel = 4'h0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        got;
      logic [2:0]  rr_exp [4];
      rr_exp[0] = 3'd0; rr_exp[1] = 3'd7; rr_exp[2] = 3'd0; rr_exp[3] = 3'd7;

      // Reset state.
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_gnt_valid", 32'(gnt_valid), 0);
      check("rst_irq", 32'(irq), 0);
      check("rst_ack", 32'(ack), 0);
      rst = 1'b0;
      wb_read(8'h00, rd); check("rst_ctrl", rd, 32'h0);
      wb_read(8'h04, rd); check("rst_mask", rd, 32'hFF);
      wb_read(8'h08, rd); check("rst_pend", rd, 32'h0);
      wb_read(8'h0C, rd); check("rst_grant", rd, 32'h0);
      check("rst_gnt", 32'(gnt), 0);

      // Fixed priority: pulse 0x24, highest (5) wins, then 2 after ACK.
      wb_write(8'h00, 32'h5, 4'hF);
      req = 8'h24;
      @(posedge clk); #1;
      req = 8'h00;
      check("fx_no_gnt_yet", 32'(gnt_valid), 0);
      @(posedge clk); #1;
      check("fx_valid", 32'(gnt_valid), 1);
      check("fx_idx", 32'(gnt_idx), 5);
      check("fx_onehot", 32'(gnt), 32'h20);
      check("fx_irq_lag", 32'(irq), 0);
      @(posedge clk); #1;
      check("fx_irq", 32'(irq), 1);
      wb_read(8'h0C, rd); check("fx_grant_reg", rd, 32'h8000_0005);
      wb_read(8'h08, rd); check("fx_pend_both", rd, 32'h24);
      wb_write(8'h10, 32'h1, 4'h1);
      check("fx_retire_valid", 32'(gnt_valid), 1);
      @(posedge clk); #1;
      check("fx_idle_valid", 32'(gnt_valid), 0);
      @(posedge clk); #1;
      check("fx_second_valid", 32'(gnt_valid), 1);
      check("fx_second_idx", 32'(gnt_idx), 2);
      wb_read(8'h08, rd); check("fx_pend_left", rd, 32'h04);
      wb_write(8'h10, 32'h1, 4'h1);
      @(posedge clk); #1;
      check("fx_done_valid", 32'(gnt_valid), 0);

      // Round-robin with 0x81 held: 0,7,0,7 with a 3-cycle turnaround.
      do_reset();
      wb_write(8'h00, 32'h7, 4'hF);
      req = 8'h81;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge clk); #1;
         if (gnt_valid) got = 1'b1;
      end
      check("rr_first_grant", 32'(got), 1);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("rr_idx%0d", k), 32'(gnt_idx), 32'(rr_exp[k]));
         check($sformatf("rr_onehot%0d", k), 32'(gnt), 32'(8'h1 << rr_exp[k]));
         wb_write(8'h10, 32'h1, 4'h1);
         @(posedge clk); #1;
         check($sformatf("rr_idle%0d", k), 32'(gnt_valid), 0);
         @(posedge clk); #1;
         check($sformatf("rr_regrant%0d", k), 32'(gnt_valid), 1);
      end
      // Reset while a grant is outstanding.
      rst = 1'b1;
      req = 8'h00;
      @(posedge clk); #1;
      check("midrst_valid", 32'(gnt_valid), 0);
      check("midrst_gnt", 32'(gnt), 0);
      check("midrst_irq", 32'(irq), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Masked request does not win until unmasked.
      wb_write(8'h04, 32'h7F, 4'hF);
      wb_write(8'h00, 32'h1, 4'hF);
      req = 8'h80;
      @(posedge clk); #1;
      req = 8'h00;
      repeat (3) begin @(posedge clk); #1; end
      check("mask_no_gnt", 32'(gnt_valid), 0);
      wb_read(8'h08, rd); check("mask_pend", rd, 32'h80);
      wb_write(8'h04, 32'hFF, 4'hF);
      check("unmask_not_yet", 32'(gnt_valid), 0);
      @(posedge clk); #1;
      check("unmask_valid", 32'(gnt_valid), 1);
      check("unmask_idx", 32'(gnt_idx), 7);

      // EN drop keeps pending; re-enable regrants the same index.
      wb_write(8'h00, 32'h0, 4'hF);
      check("endrop_still", 32'(gnt_valid), 1);
      @(posedge clk); #1;
      check("endrop_valid", 32'(gnt_valid), 0);
      wb_read(8'h08, rd); check("endrop_pend", rd, 32'h80);
      wb_write(8'h00, 32'h1, 4'hF);
      @(posedge clk); #1;
      check("reen_valid", 32'(gnt_valid), 1);
      check("reen_idx", 32'(gnt_idx), 7);
      // Masking or W1C of the granted bit does not revoke the grant.
      wb_write(8'h04, 32'h7F, 4'hF);
      @(posedge clk); #1;
      check("mask_keep_valid", 32'(gnt_valid), 1);
      wb_write(8'h08, 32'h80, 4'hF);
      wb_read(8'h08, rd); check("w1c_pend", rd, 32'h0);
      check("w1c_keep_valid", 32'(gnt_valid), 1);
      check("w1c_keep_idx", 32'(gnt_idx), 7);
      wb_write(8'h10, 32'h1, 4'h1);
      @(posedge clk); #1;
      check("w1c_ack_valid", 32'(gnt_valid), 0);
      // ACK while idle has no effect on pending.
      wb_write(8'h00, 32'h0, 4'hF);
      req = 8'h01;
      @(posedge clk); #1;
      req = 8'h00;
      wb_write(8'h10, 32'h1, 4'h1);
      wb_read(8'h08, rd); check("idle_ack_pend", rd, 32'h01);
      check("idle_ack_valid", 32'(gnt_valid), 0);

      // Byte selects and out-of-window accesses.
      wb_write(8'h04, 32'h0, 4'h0);
      wb_read(8'h04, rd); check("sel0_mask", rd, 32'h7F);
      wb_write(8'h04, 32'hFFFF_FF0F, 4'h1);
      wb_read(8'h04, rd); check("sel1_mask", rd, 32'h0F);
      stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'h3000_1004; dat_w = 32'h0; sel = 4'hF;
      got = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (ack) got = 1'b1;
      end
      stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
      check("oow_no_ack", 32'(got), 0);
      wb_read(8'h04, rd); check("oow_mask", rd, 32'h0F);
      wb_read(8'h1C, rd); check("hole_data", rd, 32'h0);
      check("hole_ack_once", 32'(ack), 0);
      // Strobe held across cycles: ack pattern 1,0,1.
      stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE | 32'h1C; sel = 4'hF;
      @(posedge clk); #1; check("b2b_ack0", 32'(ack), 1);
      @(posedge clk); #1; check("b2b_ack1", 32'(ack), 0);
      @(posedge clk); #1; check("b2b_ack2", 32'(ack), 1);
      stb = 1'b0; cyc = 1'b0; sel = 4'h0;
      @(posedge clk); #1; check("b2b_ack3", 32'(ack), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
